// File: rtl/rs232_rx_frame_ctrl.sv
// Frame controller for the RS-232 byte receiver: hunts SYNC, captures a
// length-prefixed XOR-checked frame, then drains the payload on a valid/ready stream.
module rs232_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         LEN_W     = 5
) (
    input  logic             clock,
    input  logic             reset_neg,
    input  logic             rx_dataout_ready,
    input  logic [7:0]       rx_dataout,
    input  logic             rx_endofpacket,
    input  logic             abort,
    output logic             rx_flush,
    output logic             frm_valid,
    input  logic             frm_ready,
    output logic [7:0]       frm_data,
    output logic             frm_last,
    output logic [LEN_W-1:0] frm_len,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic             overrun,
    output logic [7:0]       ok_count,
    output logic [7:0]       err_count
);

    localparam int         DEPTH     = 1 << LEN_W;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_DRAIN, ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        E_CSUM = 2'd0, E_LEN = 2'd1, E_TIMEOUT = 2'd2, E_ABORT = 2'd3
    } err_t;

    state_t           state, state_nxt;
    err_t             fault_code;
    logic [LEN_W-1:0] len, len_m1, wr_idx, rd_idx;
    logic [7:0]       csum;
    logic [7:0]       mem [DEPTH];
    logic             rd_last, accept;

    assign len_m1  = len - LEN_W'(1);
    assign rd_last = (rd_idx == len_m1);
    // A byte is consumed only in a capture state and only when no abort overrides it.
    assign accept  = rx_dataout_ready && !abort;

    always_ff @(posedge clock) begin
        if (!reset_neg) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        fault_code = E_CSUM;
        case (state)
            ST_IDLE:
                if (rx_dataout_ready && rx_dataout == SYNC_BYTE) state_nxt = ST_LEN;
            ST_LEN:
                if (abort) begin
                    state_nxt = ST_ERROR; fault_code = E_ABORT;
                end else if (rx_dataout_ready) begin
                    if (rx_dataout == 8'd0 || rx_dataout > MAX_LEN_B) begin
                        state_nxt = ST_ERROR; fault_code = E_LEN;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end else if (rx_endofpacket) begin
                    state_nxt = ST_ERROR; fault_code = E_TIMEOUT;
                end
            ST_PAYLOAD:
                if (abort) begin
                    state_nxt = ST_ERROR; fault_code = E_ABORT;
                end else if (rx_dataout_ready) begin
                    if (wr_idx == len_m1) state_nxt = ST_CSUM;
                end else if (rx_endofpacket) begin
                    state_nxt = ST_ERROR; fault_code = E_TIMEOUT;
                end
            ST_CSUM:
                if (abort) begin
                    state_nxt = ST_ERROR; fault_code = E_ABORT;
                end else if (rx_dataout_ready) begin
                    if (rx_dataout == csum) state_nxt = ST_DRAIN;
                    else                    state_nxt = ST_ERROR;
                end else if (rx_endofpacket) begin
                    state_nxt = ST_ERROR; fault_code = E_TIMEOUT;
                end
            ST_DRAIN:
                if (abort) begin
                    state_nxt = ST_ERROR; fault_code = E_ABORT;
                end else if (frm_ready && rd_last) begin
                    state_nxt = ST_IDLE;
                end
            ST_ERROR: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frm_valid = (state == ST_DRAIN);
        frm_data  = frm_valid ? mem[rd_idx] : 8'd0;
        frm_last  = frm_valid && rd_last;
        frm_len   = frm_valid ? len : '0;
        err_valid = (state == ST_ERROR);
        rx_flush  = (state == ST_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_neg) begin
            len       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            csum      <= '0;
            err_code  <= '0;
            overrun   <= 1'b0;
            ok_count  <= '0;
            err_count <= '0;
        end else begin
            if (state_nxt == ST_ERROR) err_code <= fault_code;
            case (state)
                ST_IDLE: begin
                    wr_idx <= '0;
                    rd_idx <= '0;
                    if (abort) overrun <= 1'b0;
                end
                ST_LEN:
                    if (accept) begin
                        len  <= LEN_W'(rx_dataout);
                        csum <= rx_dataout;
                    end
                ST_PAYLOAD:
                    if (accept) begin
                        wr_idx <= wr_idx + LEN_W'(1);
                        csum   <= csum ^ rx_dataout;
                    end
                ST_CSUM:
                    if (accept && rx_dataout == csum) ok_count <= ok_count + 8'd1;
                ST_DRAIN:
                    if (!abort) begin
                        if (frm_ready)        rd_idx  <= rd_idx + LEN_W'(1);
                        if (rx_dataout_ready) overrun <= 1'b1;
                    end
                ST_ERROR: err_count <= err_count + 8'd1;
                default: ;
            endcase
        end
    end

    // NOTE: the payload buffer has no reset; its contents are only read after being written in the same frame.
    always_ff @(posedge clock) begin
        if (state == ST_PAYLOAD && accept) mem[wr_idx] <= rx_dataout;
    end

endmodule

// File: doc/rs232_rx_frame_ctrl.md
# rs232_rx_frame_ctrl

Frame controller sequencing the RS-232 byte receiver. It hunts for a sync byte and captures a length-prefixed, XOR-checked frame into an internal buffer. A validated payload is then released over a valid/ready stream. On any framing fault it pulses the receiver's synchronous clear (`Exe_LogicImp`) to resynchronise, so upper layers see only whole, checked frames.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_LEN`, 16, maximum payload bytes (1..255)
- `LEN_W`, 5, width of length/index fields; MAX_LEN < 2**LEN_W required
- `clock`  in  1  single clock, rising edge
- `reset_neg`  in  1  synchronous, active-low reset
- `rx_dataout_ready`  in  1  one-cycle byte strobe from receiver
- `rx_dataout`  in  8  received byte, valid with strobe
- `rx_endofpacket`  in  1  one-cycle line-gap pulse from receiver
- `abort`  in  1  software abort, level, sampled each cycle
- `rx_flush`  out  1  drives receiver `Exe_LogicImp`; one-cycle pulse
- `frm_valid`  out  1  payload byte available
- `frm_ready`  in  1  downstream accepts byte
- `frm_data`  out  8  payload byte
- `frm_last`  out  1  marks final payload byte
- `frm_len`  out  LEN_W  length of frame being drained
- `err_valid`  out  1  one-cycle error report
- `err_code`  out  2  0=checksum, 1=bad length, 2=timeout, 3=abort; held until next error
- `overrun`  out  1  sticky: byte dropped while draining
- `ok_count`  out  8  good frames, wraps 255->0
- `err_count`  out  8  errored frames, wraps 255->0

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN, ERROR.
- IDLE: strobe with byte==SYNC_BYTE -> LEN. Other bytes are discarded silently. `rx_endofpacket` is ignored.
- LEN: strobe latches byte as length and seeds csum=byte.
  - Length 0 or >MAX_LEN -> ERROR, code 1.
  - Otherwise -> PAYLOAD with index=0.
- PAYLOAD: each strobe writes buf[index], csum^=byte, index++. After the length-th byte -> CSUM.
- CSUM: strobe compares byte against csum.
  - Equal -> DRAIN, ok_count++.
  - Unequal -> ERROR, code 0.
- LEN/PAYLOAD/CSUM: `rx_endofpacket` without a strobe in the same cycle -> ERROR, code 2. If both occur in the same cycle, the byte is processed and the gap pulse is ignored.
- DRAIN:
  - `frm_valid`=1, `frm_data`=buf[rd_idx], `frm_last`=(rd_idx==len-1), `frm_len`=len.
  - Handshake (valid&ready) increments rd_idx. Handshake on the last byte -> IDLE.
  - A strobe arriving during DRAIN drops the byte and sets `overrun`.
- ERROR: lasts exactly one cycle.
  - Outputs `rx_flush`=1 and `err_valid`=1; `err_count`++ -> IDLE.
  - A strobe arriving in this cycle is dropped; `overrun` is not set.
- Abort:
  - `abort`=1 in any state other than IDLE or ERROR -> ERROR, code 3. This has priority over strobe and gap pulse.
  - `abort` in IDLE clears `overrun` only; no error is reported.
- Width rules:
  - Index and length are LEN_W bits.
  - Checksum is the 8-bit XOR of the length byte and all payload bytes.
  - Counters are 8-bit modulo.

## Timing
- Reset (reset_neg=0 at an edge): state=IDLE, all outputs 0, `err_code`=0, counters=0, `overrun`=0, buffer contents don't-care. Reset overrides abort and any state, including mid-frame and mid-drain.
- Strobe at edge t is registered; the state change is visible after edge t.
- `frm_valid` rises the cycle after the CSUM strobe (1-cycle latency).
- DRAIN delivers 1 byte/cycle while `frm_ready`=1.
- `frm_data`/`frm_last` are stable while valid&~ready. Valid never drops before the handshake.
- `err_valid`, `rx_flush` and the `err_count` increment all occur in the single ERROR cycle, the cycle after the faulting event. `err_code` updates in that same cycle.
- A back-to-back frame is possible: SYNC accepted the cycle after the last drain handshake.

## Test plan
- Good frame: A5, 03, 11, 22, 33, csum 03^11^22^33=0x03 -> `frm_data` 11,22,33 with `frm_last` on 33, `frm_len`=3, `ok_count`=1, no `rx_flush`.
- Bad checksum: A5, 02, 10, 20, 00 -> no `frm_valid`; one cycle of `err_valid`=1, code 0, `rx_flush`=1; `err_count`=1.
- Bad length: A5, 00 and A5, 11 (17 > MAX_LEN) -> code 1 each time, `err_count`=2. A following good frame is delivered intact.
- Timeout/collision:
  - A5, 04, AA then `rx_endofpacket` -> code 2.
  - Strobe and gap pulse in the same PAYLOAD cycle -> byte stored, no error.
- Backpressure/overrun:
  - Good 4-byte frame with `frm_ready` toggling 1,0,0,1,... -> data held stable across stalls.
  - Strobe injected during drain -> `overrun`=1, payload unaffected.
  - `abort` pulse in IDLE -> `overrun` cleared.
- Abort/reset mid-frame:
  - `abort` in PAYLOAD -> code 3, `rx_flush` pulse.
  - `reset_neg`=0 during DRAIN -> all outputs and counters 0 next cycle, IDLE.
